// File: rtl/player_motion_if.sv
// Maze BRAM read port used by player_motion: address out, registered data back one cycle later.
interface player_motion_if;
    logic [7:0] bram_addr;
    logic [8:0] bram_data_out;

    modport master (output bram_addr, input bram_data_out);
    modport slave  (input bram_addr, output bram_data_out);
endinterface

// File: rtl/player_motion.sv
// Grid-movement controller: button -> wall/bot check via maze BRAM -> 7-step tile slide.
// Produces committed player cell, sub-tile scroll offsets and facing direction.
module player_motion #(
    parameter int MAZE_SIZE = 16,
    parameter int START_X   = 1,
    parameter int START_Y   = 1,
    parameter int START_DIR = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  step_tick,
    input  logic                  btn_up,
    input  logic                  btn_right,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic [3:0]            botX,
    input  logic [3:0]            botY,
    player_motion_if.master       bram,
    output logic [3:0]            playerX,
    output logic [3:0]            playerY,
    output logic [2:0]            chunkX,
    output logic [2:0]            chunkY,
    output logic [1:0]            dir,
    output logic                  moving,
    output logic                  blocked,
    output logic                  move_done
);

    typedef enum logic [2:0] {IDLE, FETCH, CHECK, SLIDE_OUT, SLIDE_IN} state_t;

    localparam logic [2:0] CENTRE = 3'd3;
    localparam logic [2:0] EDGE_HI = 3'd6;

    state_t     state;
    logic [3:0] tgt_x, tgt_y;
    logic       mv_horiz;
    logic       mv_pos;

    logic       btn_any;
    logic [1:0] btn_dir;
    logic [4:0] nx5, ny5;
    logic       off_grid;
    logic [7:0] tgt_addr;
    logic [2:0] chunk_cur, chunk_fwd, chunk_nxt;
    logic       at_edge;

    logic unused_bram_bits;
    assign unused_bram_bits = ^bram.bram_data_out[8:1];

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        btn_any = btn_up | btn_right | btn_down | btn_left;
        btn_dir = 2'd0;
        if (btn_up)         btn_dir = 2'd0;
        else if (btn_right) btn_dir = 2'd1;
        else if (btn_down)  btn_dir = 2'd2;
        else if (btn_left)  btn_dir = 2'd3;

        // 5-bit target so that 0-1 and 15+1 both land at or beyond MAZE_SIZE
        nx5 = {1'b0, playerX};
        ny5 = {1'b0, playerY};
        unique case (btn_dir)
            2'd0: ny5 = ny5 - 5'd1;
            2'd1: nx5 = nx5 + 5'd1;
            2'd2: ny5 = ny5 + 5'd1;
            2'd3: nx5 = nx5 - 5'd1;
        endcase
        off_grid = (nx5 >= 5'(MAZE_SIZE)) || (ny5 >= 5'(MAZE_SIZE));
        tgt_addr = 8'(int'(ny5) * MAZE_SIZE + int'(nx5));

        chunk_cur = mv_horiz ? chunkX : chunkY;
        chunk_fwd = mv_pos ? chunk_cur + 3'd1 : chunk_cur - 3'd1;
        at_edge   = mv_pos ? (chunk_cur == EDGE_HI) : (chunk_cur == 3'd0);
        chunk_nxt = chunk_fwd;
        if (state == SLIDE_OUT && at_edge)
            chunk_nxt = mv_pos ? 3'd0 : EDGE_HI;
    end

    // NOTE: all state and outputs are registered with non-blocking assignments; pulses are
    // cleared by default each enabled cycle and set only on the cycle they fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            playerX        <= 4'(START_X);
            playerY        <= 4'(START_Y);
            chunkX         <= CENTRE;
            chunkY         <= CENTRE;
            dir            <= 2'(START_DIR);
            bram.bram_addr <= 8'd0;
            moving         <= 1'b0;
            blocked        <= 1'b0;
            move_done      <= 1'b0;
            tgt_x          <= 4'd0;
            tgt_y          <= 4'd0;
            mv_horiz       <= 1'b0;
            mv_pos         <= 1'b0;
        end else if (!en) begin
            blocked   <= 1'b0;
            move_done <= 1'b0;
        end else begin
            blocked   <= 1'b0;
            move_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (btn_any) begin
                        dir <= btn_dir;
                        if (off_grid) begin
                            blocked <= 1'b1;
                        end else begin
                            bram.bram_addr <= tgt_addr;
                            tgt_x          <= nx5[3:0];
                            tgt_y          <= ny5[3:0];
                            mv_horiz       <= btn_dir[0];
                            mv_pos         <= (btn_dir == 2'd1) || (btn_dir == 2'd2);
                            moving         <= 1'b1;
                            state          <= FETCH;
                        end
                    end
                end
                FETCH: state <= CHECK;
                CHECK: begin
                    if (bram.bram_data_out[0] || (tgt_x == botX && tgt_y == botY)) begin
                        blocked <= 1'b1;
                        moving  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= SLIDE_OUT;
                    end
                end
                SLIDE_OUT: begin
                    if (step_tick) begin
                        if (mv_horiz) chunkX <= chunk_nxt;
                        else          chunkY <= chunk_nxt;
                        if (at_edge) begin
                            // the non-moving axis of the target equals the current cell
                            playerX <= tgt_x;
                            playerY <= tgt_y;
                            state   <= SLIDE_IN;
                        end
                    end
                end
                SLIDE_IN: begin
                    if (step_tick) begin
                        if (mv_horiz) chunkX <= chunk_nxt;
                        else          chunkY <= chunk_nxt;
                        if (chunk_nxt == CENTRE) begin
                            moving    <= 1'b0;
                            move_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
